// File: rtl/rijndael_pkg.sv
// Shared Rijndael datapath constants and byte-addressing helper.
package rijndael_pkg;

    localparam int STATE_W          = 128;
    localparam int SBOX_ROM_LATENCY = 1;

    // LSB offset of byte i within an nbytes-wide state; byte 0 sits at the MSB end.
    function automatic int byte_lsb(input int i, input int nbytes);
        return 8 * (nbytes - 1 - i);
    endfunction

endpackage

// File: rtl/sub_bytes_engine.sv
// Byte-serial SubBytes/InvSubBytes through the shared S-box ROM; done NBYTES+ROM_LATENCY+1 cycles after start.
// No backpressure: start is honoured only in IDLE and ignored (not queued) while busy or in DONE.
module sub_bytes_engine
    import rijndael_pkg::*;
#(
    parameter int NBYTES      = STATE_W / 8,
    parameter int ROM_LATENCY = SBOX_ROM_LATENCY
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                invbytes,
    input  logic [8*NBYTES-1:0] state_in,
    output logic [8*NBYTES-1:0] state_out,
    output logic                busy,
    output logic                done,
    output logic [7:0]          rom_add,
    output logic                rom_en,
    output logic                rom_invbytes,
    input  logic [7:0]          rom_dout
);

    localparam int IW = $clog2(NBYTES);
    localparam int SW = 8 * NBYTES;
    localparam int OW = $clog2(SW);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} fsm_e;

    fsm_e                 state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 mode_q, mode_d;
    logic [SW-1:0]        data_q, data_d;
    logic [1:0]           drain_q, drain_d;
    logic [ROM_LATENCY-1:0] cap_vld_q;
    logic [IW-1:0]        cap_idx_q [ROM_LATENCY];
    logic [OW-1:0]        rd_lsb, wr_lsb;

    assign rd_lsb       = OW'(byte_lsb(int'(idx_q), NBYTES));
    assign wr_lsb       = OW'(byte_lsb(int'(cap_idx_q[ROM_LATENCY-1]), NBYTES));
    assign state_out    = data_q;
    assign rom_invbytes = mode_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        data_d  = data_q;
        drain_d = '0;
        rom_en  = 1'b0;
        rom_add = '0;
        busy    = 1'b0;
        done    = 1'b0;

        // A byte is read once at issue and written back only ROM_LATENCY cycles later.
        if (cap_vld_q[ROM_LATENCY-1]) begin
            data_d[wr_lsb +: 8] = rom_dout;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    data_d  = state_in;
                    mode_d  = invbytes;
                    idx_d   = '0;
                end
            end
            S_ISSUE: begin
                busy    = 1'b1;
                rom_en  = 1'b1;
                rom_add = data_q[rd_lsb +: 8];
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NBYTES - 1)) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                drain_d = drain_q + 1'b1;
                if (drain_q == 2'(ROM_LATENCY - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_vld_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                cap_idx_q[i] <= '0;
            end
        end else begin
            cap_vld_q[0] <= (state_q == S_ISSUE);
            cap_idx_q[0] <= idx_q;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                cap_vld_q[i] <= cap_vld_q[i-1];
                cap_idx_q[i] <= cap_idx_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine at ROM latency 1 and 2 with an S-box ROM model.
module tb_sub_bytes_engine;

    logic         clock = 1'b0;
    logic         reset;
    logic         start1, start2, invbytes;
    logic [127:0] state_in;
    logic [127:0] so1, so2;
    logic         busy1, busy2, done1, done2, en1, en2, inv1, inv2;
    logic [7:0]   add1, add2, dout1, dout2;

    always #5 clock = ~clock;

    sub_bytes_engine #(.NBYTES(16), .ROM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .invbytes(invbytes),
        .state_in(state_in), .state_out(so1), .busy(busy1), .done(done1),
        .rom_add(add1), .rom_en(en1), .rom_invbytes(inv1), .rom_dout(dout1)
    );

    sub_bytes_engine #(.NBYTES(16), .ROM_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .invbytes(invbytes),
        .state_in(state_in), .state_out(so2), .busy(busy2), .done(done2),
        .rom_add(add2), .rom_en(en2), .rom_invbytes(inv2), .rom_dout(dout2)
    );

    // ROM model: address registered on enable, table select applied combinationally at the output.
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    logic [7:0] ra1_q, ra2_q, ra2_qq;

    always @(posedge clock) begin
        if (en1) ra1_q <= add1;
        if (en2) ra2_q <= add2;
        ra2_qq <= ra2_q;
    end

    assign dout1 = inv1 ? isb[ra1_q] : sb[ra1_q];
    assign dout2 = inv2 ? isb[ra2_qq] : sb[ra2_qq];

    int sel_g;
    logic [127:0] so_s;
    logic         busy_s, done_s, en_s, inv_s;
    logic [7:0]   add_s;
    assign so_s   = (sel_g == 1) ? so1   : so2;
    assign busy_s = (sel_g == 1) ? busy1 : busy2;
    assign done_s = (sel_g == 1) ? done1 : done2;
    assign en_s   = (sel_g == 1) ? en1   : en2;
    assign inv_s  = (sel_g == 1) ? inv1  : inv2;
    assign add_s  = (sel_g == 1) ? add1  : add2;

    int           checks   = 0;
    int           failures = 0;
    int           done_cyc, done_cnt;
    logic [63:0]  en_mask, inv_mask, busy_mask;
    logic [127:0] add_seq, res, final_so;
    logic [159:0] rst_snap;

    localparam logic [127:0] V_PT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_SB = 128'hd42711aee0bf98f1b8b45de51e415230;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an operation on the selected DUT and records 40 cycles of activity (cycle 1 = first after start).
    task automatic run_op(input int sel, input logic [127:0] din, input logic inv,
                          input int poke_cyc, input int rst_cyc);
        sel_g    = sel;
        state_in = din;
        invbytes = inv;
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clock);
        start1    = 1'b0;
        start2    = 1'b0;
        done_cyc  = 0;
        done_cnt  = 0;
        en_mask   = '0;
        inv_mask  = '0;
        busy_mask = '0;
        add_seq   = '0;
        res       = '0;
        rst_snap  = '1;
        for (int c = 1; c <= 40; c++) begin
            if (rst_cyc != 0 && c == rst_cyc + 1) reset = 1'b0;
            if (c == rst_cyc) begin
                reset = 1'b1;
                #1;
                rst_snap = {20'h0, so_s, busy_s, done_s, en_s, add_s, inv_s};
            end
            if (done_s) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    res      = so_s;
                end
            end
            busy_mask[c] = busy_s;
            en_mask[c]   = en_s;
            inv_mask[c]  = inv_s;
            if (en_s) add_seq = {add_seq[119:0], add_s};
            if (c == poke_cyc) begin
                state_in = ~din;
                invbytes = 1'b1;
                if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
            end
            @(negedge clock);
            start1 = 1'b0;
            start2 = 1'b0;
        end
        final_so = so_s;
    endtask

    initial begin
        logic [2047:0] sbox_flat;
        reset    = 1'b1;
        start1   = 1'b0;
        start2   = 1'b0;
        invbytes = 1'b0;
        state_in = '0;
        sel_g    = 1;
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) begin
            sb[i] = sbox_flat[2047 - 8*i -: 8];
        end
        for (int i = 0; i < 256; i++) begin
            isb[sb[i]] = 8'(i);
        end

        repeat (2) @(negedge clock);
        check("in_reset_dut1", {20'h0, so1, busy1, done1, en1, add1, inv1}, '0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_dut1", {20'h0, so1, busy1, done1, en1, add1, inv1}, '0);
        check("idle_dut2", {20'h0, so2, busy2, done2, en2, add2, inv2}, '0);

        // SubBytes, latency 1
        run_op(1, V_PT, 1'b0, 0, 0);
        check("sub_result", res, V_SB);
        check("sub_done_cycle", done_cyc, 18);
        check("sub_done_count", done_cnt, 1);
        check("sub_rom_en_cycles", en_mask, 64'h1FFFE);
        check("sub_busy_cycles", busy_mask, 64'h3FFFE);
        check("sub_hold_idle", final_so, V_SB);

        // InvSubBytes round trip
        run_op(1, V_SB, 1'b1, 0, 0);
        check("inv_result", res, V_PT);
        check("inv_done_cycle", done_cyc, 18);
        check("inv_rom_invbytes", inv_mask & 64'h3FFFE, 64'h3FFFE);

        // Byte order: byte 0 is the MSB and is issued first
        run_op(1, {8'h00, {15{8'hFF}}}, 1'b0, 0, 0);
        check("order_result", res, {8'h63, {15{8'h16}}});
        check("order_rom_add_seq", add_seq, {8'h00, {15{8'hFF}}});

        // Start with new data and mode while busy is ignored
        run_op(1, V_PT, 1'b0, 5, 0);
        check("poke_result", res, V_SB);
        check("poke_done_count", done_cnt, 1);
        check("poke_done_cycle", done_cyc, 18);
        check("poke_hold_idle", final_so, V_SB);
        check("poke_mode_stable", inv_mask, 64'h0);

        // Asynchronous reset mid-operation
        run_op(1, V_PT, 1'b0, 0, 9);
        check("rst_outputs_zero", rst_snap, '0);
        check("rst_no_done", done_cnt, 0);
        check("rst_state_cleared", final_so, '0);
        run_op(1, V_PT, 1'b0, 0, 0);
        check("after_rst_result", res, V_SB);
        check("after_rst_done_cycle", done_cyc, 18);

        // ROM latency 2
        run_op(2, V_PT, 1'b0, 0, 0);
        check("lat2_result", res, V_SB);
        check("lat2_done_cycle", done_cyc, 19);
        check("lat2_busy_cycles", busy_mask, 64'h7FFFE);
        check("lat2_done_count", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
